// File: rtl/alu_rr_scheduler.sv
// -----------------------------------------------------------------------------
// alu_rr_scheduler
//
// Purpose
//   Shares one registered ALU between two requesters. A round-robin arbiter
//   picks one requester in IDLE. Its op/a/b are captured into operand
//   registers that drive the ALU. After ALU_LAT + 1 edges the ALU result is
//   captured into the owner's response registers. The response is held until
//   the owner takes it. Only one operation is in flight at a time. The
//   opcode is forwarded unmodified and is never decoded here.
//
// Parameters
//   DATA_W   operand/result width
//   OP_W     opcode width
//   ALU_LAT  ALU clock edges from operand sample to result valid
//            (0 = combinational ALU)
//
// Ports
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   reqN_valid / reqN_ready    request handshake, requester N (N = 0, 1)
//   reqN_op / reqN_a / reqN_b  request opcode and operands
//   rspN_valid / rspN_ready    response handshake, requester N
//   rspN_result / rspN_carry   captured ALU result and carry
//   alu_op / alu_a / alu_b     operands to the ALU, held stable while busy
//   alu_result / alu_carry     result and carry from the ALU
//   busy                       scheduler not in IDLE
//   grant_cnt0 / grant_cnt1    saturating accept counters, one per requester
//
// Configuration
//   ALU_SCHED_STATS_EN  defined: 8-bit saturating grant counters are built.
//                       undefined: grant_cnt0/1 are tied to zero.
// -----------------------------------------------------------------------------
module alu_rr_scheduler #(
  parameter int DATA_W  = 4,
  parameter int OP_W    = 3,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  // requester 0
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  // requester 1
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  // response 0
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_carry,
  // response 1
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_carry,
  // shared ALU
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  // status
  output logic              busy,
  output logic [7:0]        grant_cnt0,
  output logic [7:0]        grant_cnt1
);

  // Counter width for the ALU latency countdown; at least one bit.
  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ALU_LAT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Owner of the op in flight and the most recent winner.
  // A value of 0 means requester 0 and a value of 1 means requester 1.
  logic owner_q,      owner_d;
  logic last_grant_q, last_grant_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] a_q,  a_d;
  logic [DATA_W-1:0] b_q,  b_d;

  logic [DATA_W-1:0] rsp0_result_q, rsp0_result_d;
  logic              rsp0_carry_q,  rsp0_carry_d;
  logic [DATA_W-1:0] rsp1_result_q, rsp1_result_d;
  logic              rsp1_carry_q,  rsp1_carry_d;

  logic grant0, grant1;
  logic acc0, acc1, accept;
  logic rsp_hs;

  // ---------------------------------------------------------------------------
  // Round-robin arbitration. It is purely combinational from the valids, so it
  // is re-evaluated every IDLE cycle. On a tie, the requester that did not win
  // last time is granted.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned and infers a latch.
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = last_grant_q;
      grant1 = ~last_grant_q;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  assign acc0   = req0_valid & req0_ready;
  assign acc1   = req1_valid & req1_ready;
  assign accept = acc0 | acc1;
  assign rsp_hs = (state_q == RESP) & (owner_q ? rsp1_ready : rsp0_ready);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of block ordering.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)         state_d = BUSY;
      BUSY:    if (cnt_q == '0)    state_d = RESP;
      RESP:    if (rsp_hs)         state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. The readies are gated by rst so that nothing is accepted in
  // the reset cycle itself.
  // ---------------------------------------------------------------------------
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    busy       = 1'b0;
    unique case (state_q)
      IDLE: begin
        req0_ready = grant0 & ~rst;
        req1_ready = grant1 & ~rst;
      end
      BUSY: busy = 1'b1;
      RESP: begin
        busy       = 1'b1;
        rsp0_valid = ~owner_q;
        rsp1_valid = owner_q;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    rsp0_result_d = rsp0_result_q;
    rsp0_carry_d  = rsp0_carry_q;
    rsp1_result_d = rsp1_result_q;
    rsp1_carry_d  = rsp1_carry_q;

    // Accept: at most one ready is high, so acc1 alone selects the source.
    if (accept) begin
      op_d         = acc1 ? req1_op : req0_op;
      a_d          = acc1 ? req1_a  : req0_a;
      b_d          = acc1 ? req1_b  : req0_b;
      owner_d      = acc1;
      last_grant_d = acc1;
      cnt_d        = CNT_INIT;
    end

    // The countdown ends when the ALU output reflects the held operands.
    // The result is then captured for the owner. The other response is
    // cleared so that only the owner presents data.
    if (state_q == BUSY) begin
      if (cnt_q == '0) begin
        if (owner_q) begin
          rsp1_result_d = alu_result;
          rsp1_carry_d  = alu_carry;
          rsp0_result_d = '0;
          rsp0_carry_d  = 1'b0;
        end else begin
          rsp0_result_d = alu_result;
          rsp0_carry_d  = alu_carry;
          rsp1_result_d = '0;
          rsp1_carry_d  = 1'b0;
        end
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: the operand and response registers drive ports that have defined
    // reset values, so they are reset along with the control state.
    if (rst) begin
      owner_q       <= 1'b0;
      last_grant_q  <= 1'b1;   // requester 0 wins the first contest
      cnt_q         <= '0;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      rsp0_result_q <= '0;
      rsp0_carry_q  <= 1'b0;
      rsp1_result_q <= '0;
      rsp1_carry_q  <= 1'b0;
    end else begin
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      a_q           <= a_d;
      b_q           <= b_d;
      rsp0_result_q <= rsp0_result_d;
      rsp0_carry_q  <= rsp0_carry_d;
      rsp1_result_q <= rsp1_result_d;
      rsp1_carry_q  <= rsp1_carry_d;
    end
  end

  assign alu_op      = op_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign rsp0_result = rsp0_result_q;
  assign rsp0_carry  = rsp0_carry_q;
  assign rsp1_result = rsp1_result_q;
  assign rsp1_carry  = rsp1_carry_q;

  // ---------------------------------------------------------------------------
  // Optional grant statistics
  // ---------------------------------------------------------------------------
`ifdef ALU_SCHED_STATS_EN
  logic [7:0] gcnt0_q, gcnt0_d;
  logic [7:0] gcnt1_q, gcnt1_d;

  // Saturating increment: a counter stops at 255 and never wraps.
  always_comb begin
    gcnt0_d = gcnt0_q;
    gcnt1_d = gcnt1_q;
    if (acc0 && (gcnt0_q != 8'hFF)) gcnt0_d = gcnt0_q + 8'd1;
    if (acc1 && (gcnt1_q != 8'hFF)) gcnt1_d = gcnt1_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gcnt0_q <= 8'd0;
      gcnt1_q <= 8'd0;
    end else begin
      gcnt0_q <= gcnt0_d;
      gcnt1_q <= gcnt1_d;
    end
  end

  assign grant_cnt0 = gcnt0_q;
  assign grant_cnt1 = gcnt1_q;
`else
  assign grant_cnt0 = 8'd0;
  assign grant_cnt1 = 8'd0;
`endif

  // The arbiter must never raise both readies at once.
  a_one_ready : assert property (@(posedge clk) disable iff (rst)
                                 !(req0_ready && req1_ready));

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_alu_rr_scheduler
//
// Self-checking bench for alu_rr_scheduler with ALU_LAT = 1. It models a
// registered 4-bit ALU.
//
// A negedge monitor predicts each accepted operation from the request ports
// and pushes it onto a scoreboard. On every response handshake, the monitor
// pops the scoreboard and compares. Directed sequences cover the following:
//   - reset values
//   - latency
//   - round-robin order and throughput
//   - response hold under back-pressure
//   - reset in flight
//   - grant statistics
// -----------------------------------------------------------------------------
module tb_alu_rr_scheduler;

  localparam int DATA_W  = 4;
  localparam int OP_W    = 3;
  localparam int ALU_LAT = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req0_ready;
  logic [OP_W-1:0]   req0_op;
  logic [DATA_W-1:0] req0_a, req0_b;
  logic              req1_valid, req1_ready;
  logic [OP_W-1:0]   req1_op;
  logic [DATA_W-1:0] req1_a, req1_b;
  logic              rsp0_valid, rsp0_ready, rsp0_carry;
  logic [DATA_W-1:0] rsp0_result;
  logic              rsp1_valid, rsp1_ready, rsp1_carry;
  logic [DATA_W-1:0] rsp1_result;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_a, alu_b, alu_result;
  logic              alu_carry;
  logic              busy;
  logic [7:0]        grant_cnt0, grant_cnt1;

  always #5 clk = ~clk;

  alu_rr_scheduler #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W),
    .ALU_LAT(ALU_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_result(rsp0_result),
    .rsp0_carry (rsp0_carry),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_result(rsp1_result),
    .rsp1_carry (rsp1_carry),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .busy       (busy),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
  );

  // Reference ALU. The return value is {carry, result}.
  // Opcodes: add, sub, and, or, xor, not, shr, shl.
  function automatic logic [4:0] alu_f(input logic [2:0] op,
                                       input logic [3:0] a,
                                       input logic [3:0] b);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, ~a};
      3'd6:    return {a[0], 1'b0, a[3:1]};
      default: return {a[3], a[2:0], 1'b0};
    endcase
  endfunction

  // Registered ALU wrapper: one edge from operand sample to valid result.
  always @(posedge clk) {alu_carry, alu_result} <= alu_f(alu_op, alu_a, alu_b);

  function automatic int exp_cnt(input int n);
`ifdef ALU_SCHED_STATS_EN
    return (n > 255) ? 255 : n;
`else
    return 0;
`endif
  endfunction

  typedef struct packed {
    logic       owner;
    logic       carry;
    logic [3:0] result;
  } exp_t;

  exp_t sb[$];
  int   gl_owner[$];
  int   gl_cyc[$];
  int   n_checks = 0;
  int   n_bad    = 0;
  int   cyc      = 0;
  int   acc0     = 0;
  int   acc1     = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_rsp(input logic idx, input logic [3:0] res,
                           input logic car);
    exp_t e;
    check("sb_depth", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("sb_owner",  idx, e.owner);
      check("sb_result", res, e.result);
      check("sb_carry",  car, e.carry);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: samples at negedge, predicting on accept and comparing on response.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      acc0 = 0;
      acc1 = 0;
    end else begin
      if (rsp0_valid && rsp0_ready) check_rsp(1'b0, rsp0_result, rsp0_carry);
      if (rsp1_valid && rsp1_ready) check_rsp(1'b1, rsp1_result, rsp1_carry);
      if (req0_valid && req0_ready) begin
        sb.push_back({1'b0, alu_f(req0_op, req0_a, req0_b)});
        acc0++;
        gl_owner.push_back(0);
        gl_cyc.push_back(cyc);
      end
      if (req1_valid && req1_ready) begin
        sb.push_back({1'b1, alu_f(req1_op, req1_a, req1_b)});
        acc1++;
        gl_owner.push_back(1);
        gl_cyc.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (!busy) break;
      step();
    end
    check(tag, busy, 1'b0);
  endtask

  task automatic wait_rsp(input string tag, input logic idx, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if ((idx ? rsp1_valid : rsp0_valid) == 1'b1) break;
      step();
    end
    check(tag, idx ? rsp1_valid : rsp0_valid, 1'b1);
  endtask

  // Keep req0 valid with fresh random operands until target accepts are seen.
  task automatic run_req0(input string tag, input int target, input int max_cyc);
    req0_valid = 1'b1;
    rsp0_ready = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      if (acc0 >= target) break;
      req0_op = OP_W'($urandom_range(0, 7));
      req0_a  = DATA_W'($urandom_range(0, 15));
      req0_b  = DATA_W'($urandom_range(0, 15));
      step();
    end
    req0_valid = 1'b0;
    check(tag, acc0, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Reset with both valids high.
    rst        = 1'b1;
    req0_valid = 1'b1; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b1; req1_op = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    repeat (2) step();
    check("rst_req0_ready", req0_ready, 1'b0);
    check("rst_req1_ready", req1_ready, 1'b0);
    check("rst_rsp0_valid", rsp0_valid, 1'b0);
    check("rst_rsp1_valid", rsp1_valid, 1'b0);
    check("rst_busy",       busy,       1'b0);
    check("rst_alu_op",     alu_op,     3'b000);
    check("rst_alu_a",      alu_a,      4'h0);
    check("rst_rsp0_res",   rsp0_result, 4'h0);
    check("rst_gcnt0",      grant_cnt0, 8'd0);
    check("rst_gcnt1",      grant_cnt1, 8'd0);
    rst        = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();

    // 2. Single add 7 + 5, accepted the same cycle, response two edges later.
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 4'd7; req0_b = 4'd5;
    #1;
    check("t2_ready", req0_ready, 1'b1);
    step();
    req0_valid = 1'b0;
    check("t2_busy",      busy,       1'b1);
    check("t2_alu_a",     alu_a,      4'd7);
    check("t2_rsp_early", rsp0_valid, 1'b0);
    step();
    check("t2_rsp_early2", rsp0_valid, 1'b0);
    step();
    check("t2_rsp_valid",  rsp0_valid,  1'b1);
    check("t2_rsp_result", rsp0_result, 4'hC);
    check("t2_rsp_carry",  rsp0_carry,  1'b0);
    check("t2_rsp1_quiet", rsp1_valid,  1'b0);
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    check("t2_rsp_drop", rsp0_valid, 1'b0);
    check("t2_idle",     busy,       1'b0);

    // 3. Both requesters are continuously valid: grants alternate, one every 4 cycles.
    reset_dut();
    gl_owner.delete();
    gl_cyc.delete();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (gl_owner.size() >= 4) break;
      req0_op = OP_W'($urandom_range(0, 7));
      req0_a  = DATA_W'($urandom_range(0, 15));
      req0_b  = DATA_W'($urandom_range(0, 15));
      req1_op = OP_W'($urandom_range(0, 7));
      req1_a  = DATA_W'($urandom_range(0, 15));
      req1_b  = DATA_W'($urandom_range(0, 15));
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("t3_ngrants", gl_owner.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i < gl_owner.size()) check("t3_owner", gl_owner[i], i % 2);
      if (i > 0 && i < gl_cyc.size())
        check("t3_spacing", gl_cyc[i] - gl_cyc[i-1], 4);
    end
    wait_idle("t3_drain", 10);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;

    // 4. req1 9 + 8 with back-pressure: the response is held, and req0 is locked out.
    req1_valid = 1'b1; req1_op = 3'd0; req1_a = 4'd9; req1_b = 4'd8;
    #1;
    check("t4_ready1", req1_ready, 1'b1);
    step();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = 3'd2; req0_a = 4'd1; req0_b = 4'd1;
    for (int i = 0; i < 2; i++) begin
      check("t4_busy_b",   busy,       1'b1);
      check("t4_ready0_b", req0_ready, 1'b0);
      check("t4_alu_a",    alu_a,      4'd9);
      step();
    end
    for (int i = 0; i < 5; i++) begin
      check("t4_rsp1_valid",  rsp1_valid,  1'b1);
      check("t4_rsp1_result", rsp1_result, 4'h1);
      check("t4_rsp1_carry",  rsp1_carry,  1'b1);
      check("t4_rsp0_quiet",  rsp0_valid,  1'b0);
      check("t4_busy",        busy,        1'b1);
      check("t4_ready0",      req0_ready,  1'b0);
      step();
    end
    req0_valid = 1'b0;
    rsp1_ready = 1'b1;
    step();
    rsp1_ready = 1'b0;
    check("t4_rsp1_drop", rsp1_valid, 1'b0);
    check("t4_idle",      busy,       1'b0);

    // 5. Reset while BUSY: the op is discarded, and the next op works normally.
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 4'd3; req0_b = 4'd4;
    step();
    req0_valid = 1'b0;
    check("t5_busy_pre", busy, 1'b1);
    rst        = 1'b1;
    rsp0_ready = 1'b1;
    step();
    rst = 1'b0;
    check("t5_idle", busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("t5_no_rsp0", rsp0_valid, 1'b0);
      check("t5_no_rsp1", rsp1_valid, 1'b0);
      step();
    end
    req0_valid = 1'b1; req0_op = 3'd1; req0_a = 4'd2; req0_b = 4'd5;
    #1;
    check("t5_ready", req0_ready, 1'b1);
    step();
    req0_valid = 1'b0;
    wait_rsp("t5_rsp_timeout", 1'b0, 10);
    check("t5_result", rsp0_result, 4'hD);
    check("t5_carry",  rsp0_carry,  1'b1);
    step();
    wait_idle("t5_drain", 10);

    // 6. Grant statistics: 3 accepts, then 300 accepts (saturates at 255).
    reset_dut();
    run_req0("t6_acc3", 3, 40);
    wait_idle("t6_drain3", 10);
    check("t6_gcnt0_3", grant_cnt0, exp_cnt(3));
    check("t6_gcnt1_3", grant_cnt1, exp_cnt(0));
    run_req0("t6_acc300", 300, 1400);
    wait_idle("t6_drain300", 10);
    check("t6_gcnt0_300", grant_cnt0, exp_cnt(300));
    check("t6_gcnt1_300", grant_cnt1, exp_cnt(0));
    rsp0_ready = 1'b0;

    step();
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
